sram_sweep_ctrl: RTL

//  Responder side of the start/rnw/ready/stop sweep handshake used by the memory tester.
//  On a start pulse it sweeps the whole async SRAM from address 0 to 2^SRAM_ADDR_SIZE-1:
//   - write mode: writes one word per address from wdat;
//   - read mode: returns one word per address on rdat.

---
 rtl/sram_sweep_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_sweep_ctrl.sv
// sram_sweep_ctrl
// Responder for the start/rnw/ready/stop sweep handshake. A start request
// walks the whole asynchronous SRAM from address 0 to all-ones. A write sweep
// stores one wdat word per address. A read sweep returns one word per address
// on rdat. Every SRAM pin and every handshake output is registered. The pin
// values for a state are therefore decoded from the next state, so they change
// on the same edge as the state register.
module sram_sweep_ctrl #(
    parameter int SRAM_DATA_SIZE = 8,
    parameter int SRAM_ADDR_SIZE = 19,
    parameter int WE_CYCLES      = 2,
    parameter int RD_CYCLES      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      rnw,
    output logic                      ready,
    output logic                      stop,
    output logic [SRAM_DATA_SIZE-1:0] rdat,
    input  logic [SRAM_DATA_SIZE-1:0] wdat,
    inout  wire  [SRAM_DATA_SIZE-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_SIZE-1:0] SRAM_ADDR,
    output logic                      SRAM_CE_N,
    output logic                      SRAM_OE_N,
    output logic                      SRAM_WE_N
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] W_SETUP = 3'd1;
    localparam logic [2:0] W_PULSE = 3'd2;
    localparam logic [2:0] W_HOLD  = 3'd3;
    localparam logic [2:0] R_SETUP = 3'd4;
    localparam logic [2:0] R_WAIT  = 3'd5;
    localparam logic [2:0] NEXT    = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    // One counter serves both timed states, so size it for the longer one.
    localparam int CNT_MAX = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]          WE_LAST   = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0]          RD_LAST   = CNT_W'(RD_CYCLES - 1);
    localparam logic [SRAM_ADDR_SIZE-1:0] ADDR_LAST = '1;

    logic [2:0]                state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [SRAM_ADDR_SIZE-1:0] addr_reg, addr_next;
    logic                      rnw_reg, rnw_next;
    logic [SRAM_DATA_SIZE-1:0] data_reg;
    logic [SRAM_DATA_SIZE-1:0] rdat_reg;
    logic                      ready_reg, ready_next;
    logic                      stop_reg, stop_next;
    logic                      ce_n_reg, ce_n_next;
    logic                      oe_n_reg, oe_n_next;
    logic                      we_n_reg, we_n_next;
    logic                      dq_oe_reg, dq_oe_next;

    // Sequencing: state transitions, the cycle counter and address stepping.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        rnw_next   = rnw_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    rnw_next   = rnw;
                    state_next = rnw ? R_SETUP : W_SETUP;
                end
            end
            W_SETUP: begin
                state_next = W_PULSE;
                cnt_next   = '0;
            end
            W_PULSE: begin
                if (cnt_reg == WE_LAST) begin
                    state_next = W_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            W_HOLD: begin
                state_next = NEXT;
            end
            R_SETUP: begin
                state_next = R_WAIT;
                cnt_next   = '0;
            end
            R_WAIT: begin
                if (cnt_reg == RD_LAST) begin
                    state_next = NEXT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            NEXT: begin
                // The all-ones address is the final word. The address never wraps inside a sweep.
                if (addr_reg == ADDR_LAST) begin
                    state_next = DONE;
                end else begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = rnw_reg ? R_SETUP : W_SETUP;
                end
            end
            DONE: begin
                state_next = IDLE;
                addr_next  = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pin and handshake values for the state about to be entered.
    always_comb begin
        ce_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        we_n_next  = 1'b1;
        dq_oe_next = 1'b0;
        ready_next = 1'b0;
        stop_next  = 1'b0;
        case (state_next)
            W_SETUP: ce_n_next = 1'b0;
            W_PULSE: begin
                ce_n_next  = 1'b0;
                we_n_next  = 1'b0;
                dq_oe_next = 1'b1;
            end
            W_HOLD: begin
                ce_n_next  = 1'b0;
                dq_oe_next = 1'b1;
            end
            R_SETUP, R_WAIT: begin
                ce_n_next = 1'b0;
                oe_n_next = 1'b0;
            end
            NEXT:    ready_next = 1'b1;
            DONE:    stop_next  = 1'b1;
            default: ce_n_next  = 1'b1;
        endcase
    end

    // Control registers. An asynchronous reset releases the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            rnw_reg   <= 1'b0;
            ready_reg <= 1'b0;
            stop_reg  <= 1'b0;
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            dq_oe_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            rnw_reg   <= rnw_next;
            ready_reg <= ready_next;
            stop_reg  <= stop_next;
            ce_n_reg  <= ce_n_next;
            oe_n_reg  <= oe_n_next;
            we_n_reg  <= we_n_next;
            dq_oe_reg <= dq_oe_next;
        end
    end

    // Data path. wdat is captured as W_SETUP ends so that a generator that
    // advanced on ready has one full cycle to settle. SRAM_DQ is captured as
    // the last R_WAIT cycle ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            rdat_reg <= '0;
        end else begin
            if (state_reg == W_SETUP) begin
                data_reg <= wdat;
            end
            if ((state_reg == R_WAIT) && (cnt_reg == RD_LAST)) begin
                rdat_reg <= SRAM_DQ;
            end
        end
    end

    assign SRAM_DQ   = dq_oe_reg ? data_reg : {SRAM_DATA_SIZE{1'bz}};
    assign SRAM_ADDR = addr_reg;
    assign SRAM_CE_N = ce_n_reg;
    assign SRAM_OE_N = oe_n_reg;
    assign SRAM_WE_N = we_n_reg;
    assign ready     = ready_reg;
    assign stop      = stop_reg;
    assign rdat      = rdat_reg;

endmodule
